// File: rtl/mac_acc_quant_if.sv
// Beat input and quantised result output of the MAC
// accumulate/quantise stage, both valid/ready.
interface mac_acc_quant_if #(
   parameter int BW = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [2*BW+3:0]   in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [BW-1:0]     out_data;
   logic              out_sat;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sat
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sat
   );
endinterface

// File: rtl/mac_acc_quant.sv
// Accumulates signed wide MAC results over a last-terminated
// run, then rounds, shifts and saturates to a BW-bit word.
module mac_acc_quant #(
   parameter int BW    = 16,
   parameter int FRAC  = BW - 1,
   parameter int ACC_W = 2 * BW + 8
) (
   input  logic           clk,
   input  logic           rst,
   mac_acc_quant_if.slave bus
);
   typedef enum logic {
      IDLE,
      ACCUM
   } state_t;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACC_W:0]   wide_t;

   localparam acc_t ACC_MAX =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam acc_t ACC_MIN =
      {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [BW-1:0] Q_MAX =
      {1'b0, {(BW-1){1'b1}}};
   localparam logic [BW-1:0] Q_MIN =
      {1'b1, {(BW-1){1'b0}}};
   localparam wide_t RND =
      wide_t'(1) <<< (FRAC - 1);

   state_t        state_q;
   state_t        state_d;
   acc_t          acc_q;
   acc_t          acc_d;
   logic          sat_run_q;
   logic          sat_run_d;
   logic          load;

   logic          out_valid_q;
   logic [BW-1:0] out_data_q;
   logic          out_sat_q;

   logic          fire_in;
   logic          fire_out;
   acc_t          in_sext;
   wide_t         sum_wide;
   logic          add_clip;
   acc_t          sum_sat;
   acc_t          run_sum;
   logic          run_clip;
   wide_t         q_wide;
   wide_t         q_shift;
   logic          q_clip;
   logic [BW-1:0] q_data;

   assign bus.in_ready  = ~out_valid_q | bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

   assign fire_in  = bus.in_valid & bus.in_ready;
   assign fire_out = out_valid_q & bus.out_ready;
   assign in_sext  = acc_t'($signed(bus.in_data));

   always_comb begin
      sum_wide = wide_t'(acc_q) + wide_t'(in_sext);
      add_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      sum_sat  = sum_wide[ACC_W-1:0];
      if (add_clip)
         sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;

      // A last beat from IDLE is a one-beat run: no add.
      run_sum  = (state_q == ACCUM) ? sum_sat : in_sext;
      run_clip = (state_q == ACCUM) &
                 (sat_run_q | add_clip);

      q_wide  = wide_t'(run_sum) + RND;
      q_shift = q_wide >>> FRAC;
      q_clip  = (q_shift[ACC_W:BW-1] != '0) &&
                (q_shift[ACC_W:BW-1] != '1);
      q_data  = q_shift[BW-1:0];
      if (q_clip)
         q_data = q_shift[ACC_W] ? Q_MIN : Q_MAX;
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sat_run_d = sat_run_q;
      load      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fire_in) begin
               if (bus.in_last) begin
                  load = 1'b1;
               end else begin
                  acc_d     = in_sext;
                  sat_run_d = 1'b0;
                  state_d   = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (fire_in) begin
               if (bus.in_last) begin
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  acc_d     = sum_sat;
                  sat_run_d = sat_run_q | add_clip;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         sat_run_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         sat_run_q <= sat_run_d;
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= q_data;
            out_sat_q   <= run_clip | q_clip;
         end else if (fire_out) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // A stalled result must not move.
   hold_a: assert property (
      @(posedge clk) disable iff (rst)
      (out_valid_q & ~bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) &&
       $stable(out_sat_q))
   );
endmodule
